cond_unit: RTL and testbench

Condition and flags stage sitting directly downstream of the ALU in the ARM execute path. Holds the architectural NZCV register, which is loaded from `ALUFlags` under per-group write enables. It evaluates the instruction's 4-bit condition field against the stored flags and gates the write and branch controls of the current instruction. It also returns the stored carry to the ALU `C_in` for ADC/SBC/RSC.

---
 rtl/cond_unit_if.sv | 29 ++
 rtl/cond_unit.sv | 66 ++++++
 tb/tb_cond_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_if.sv
// Execute-stage control bundle between the decode/ALU side and the condition unit.
// The master drives instruction controls and ALU flags; the slave returns gated controls.
interface cond_unit_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;

    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
    logic       C_out;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, C_out
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, C_out
    );
endinterface

// File: rtl/cond_unit.sv
// ARM condition/flags stage: holds NZCV, evaluates the condition field against the
// stored flags and gates the PC, register and memory write controls.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        CLK,
    input  logic        Reset,
    cond_unit_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Evaluated only from stored flags so nothing from ALUFlags reaches an output.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // NZ and CV groups update independently; a failed condition never touches flags.
    always_comb begin
        flags_d = flags_q;
        if (!bus.Stall && cond_ex) begin
            if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.Flags    = flags_q;
    assign bus.C_out    = flags_q[1];

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed literal checks from hand-worked cases plus
// randomized traffic compared every cycle against a behavioural NZCV model.
module tb_cond_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [3:0] m_flags = 4'b0000;

    always #5 clk = ~clk;

    cond_unit_if bus ();

    cond_unit #(
        .RESET_FLAGS (4'b0000)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Condition predicate straight from the ARM condition table.
    function automatic logic passes(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flags register.
    always @(posedge clk) begin
        if (rst) begin
            m_flags <= 4'b0000;
        end else if (!bus.Stall && passes(bus.Cond, m_flags)) begin
            m_flags <= { bus.FlagW[1] ? bus.ALUFlags[3:2] : m_flags[3:2],
                         bus.FlagW[0] ? bus.ALUFlags[1:0] : m_flags[1:0] };
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (en) begin
            logic ce;
            ce = passes(bus.Cond, m_flags);
            chk("m_flags",    bus.Flags,    m_flags);
            chk("m_c_out",    {3'b0, bus.C_out},    {3'b0, m_flags[1]});
            chk("m_cond_ex",  {3'b0, bus.CondEx},   {3'b0, ce});
            chk("m_pcsrc",    {3'b0, bus.PCSrc},    {3'b0, bus.PCS & ce});
            chk("m_regwrite", {3'b0, bus.RegWrite}, {3'b0, bus.RegW & ce & !bus.NoWrite});
            chk("m_memwrite", {3'b0, bus.MemWrite}, {3'b0, bus.MemW & ce});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.Cond = 4'b1110; bus.ALUFlags = 4'b0000; bus.FlagW = 2'b00;
        bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
        bus.NoWrite = 1'b0; bus.Stall = 1'b0;
    endtask

    // Load flags via an always-executed arithmetic op.
    task automatic load(input logic [3:0] f);
        idle();
        bus.ALUFlags = f; bus.FlagW = 2'b11;
        cyc();
        idle();
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        en  = 1'b1;

        // Reset state
        bus.Cond = 4'b0000; bus.RegW = 1'b1;
        #1;
        chk("rst_flags", bus.Flags, 4'b0000);
        chk("rst_c_out", {3'b0, bus.C_out}, 4'b0000);
        chk("rst_eq_condex", {3'b0, bus.CondEx}, 4'b0000);
        chk("rst_eq_regwrite", {3'b0, bus.RegWrite}, 4'b0000);

        // Compare then branch
        idle();
        bus.ALUFlags = 4'b0100; bus.FlagW = 2'b11; bus.Cond = 4'b1110;
        bus.NoWrite = 1'b1; bus.RegW = 1'b1;
        #1;
        chk("cmp_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        cyc();
        idle();
        bus.PCS = 1'b1; bus.Cond = 4'b0000;
        #1;
        chk("cmp_flags", bus.Flags, 4'b0100);
        chk("beq_pcsrc", {3'b0, bus.PCSrc}, 4'b0001);
        bus.Cond = 4'b0001;
        #1;
        chk("bne_pcsrc", {3'b0, bus.PCSrc}, 4'b0000);

        // Group enables
        load(4'b0010);
        chk("grp_base", bus.Flags, 4'b0010);
        bus.ALUFlags = 4'b1101; bus.FlagW = 2'b10;
        cyc();
        chk("grp_nz", bus.Flags, 4'b1110);
        bus.ALUFlags = 4'b0001; bus.FlagW = 2'b01;
        cyc();
        chk("grp_cv", bus.Flags, 4'b1101);

        // Failed condition
        load(4'b0000);
        bus.Cond = 4'b0000; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
        bus.RegW = 1'b1; bus.MemW = 1'b1;
        #1;
        chk("fail_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        chk("fail_memwrite", {3'b0, bus.MemWrite}, 4'b0000);
        cyc();
        idle();
        chk("fail_flags", bus.Flags, 4'b0000);

        // Signed and unsigned compound conditions
        load(4'b1001);
        bus.Cond = 4'b1010; #1; chk("ge_1001", {3'b0, bus.CondEx}, 4'b0001);
        bus.Cond = 4'b1011; #1; chk("lt_1001", {3'b0, bus.CondEx}, 4'b0000);
        bus.Cond = 4'b1100; #1; chk("gt_1001", {3'b0, bus.CondEx}, 4'b0001);
        bus.Cond = 4'b1101; #1; chk("le_1001", {3'b0, bus.CondEx}, 4'b0000);
        load(4'b1000);
        bus.Cond = 4'b1010; #1; chk("ge_1000", {3'b0, bus.CondEx}, 4'b0000);
        bus.Cond = 4'b1011; #1; chk("lt_1000", {3'b0, bus.CondEx}, 4'b0001);
        load(4'b0110);
        bus.Cond = 4'b1000; #1; chk("hi_0110", {3'b0, bus.CondEx}, 4'b0000);
        bus.Cond = 4'b1001; #1; chk("ls_0110", {3'b0, bus.CondEx}, 4'b0001);
        for (int i = 0; i < 16; i += 5) begin
            load(4'(i));
            bus.Cond = 4'b1111; #1;
            chk("nv_never", {3'b0, bus.CondEx}, 4'b0000);
        end

        // Stall then reset priority
        load(4'b0000);
        bus.Stall = 1'b1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold", bus.Flags, 4'b0000);
        end
        bus.Stall = 1'b0;
        cyc();
        chk("stall_release", bus.Flags, 4'b0010);
        chk("stall_c_out", {3'b0, bus.C_out}, 4'b0001);
        rst = 1'b1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
        cyc();
        chk("rst_priority", bus.Flags, 4'b0000);
        rst = 1'b0;

        // Randomized traffic; the negedge process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            bus.Cond     = 4'($urandom_range(0, 15));
            bus.ALUFlags = 4'($urandom_range(0, 15));
            bus.FlagW    = 2'($urandom_range(0, 3));
            bus.PCS      = 1'($urandom_range(0, 1));
            bus.RegW     = 1'($urandom_range(0, 1));
            bus.MemW     = 1'($urandom_range(0, 1));
            bus.NoWrite  = 1'($urandom_range(0, 1));
            bus.Stall    = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 31) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
